// File: rtl/reg_write_queue_pkg.sv
// Shared register-bank geometry and queue defaults for the register write queue.
package reg_write_queue_pkg;

  localparam int unsigned REG_AW    = 5;
  localparam int unsigned REG_DW    = 32;
  localparam int unsigned REG_NUM   = 32;
  localparam int unsigned RWQ_DEPTH = 4;

endpackage

// File: rtl/rwq_match.sv
// Combinational youngest-match search over the buffered writes for one read port.
module rwq_match
  import reg_write_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = RWQ_DEPTH,
  parameter int unsigned AWIDTH = REG_AW,
  parameter int unsigned DWIDTH = REG_DW
) (
  input  logic [AWIDTH-1:0]          q_addr,
  input  logic [AWIDTH-1:0]          ent_addr [DEPTH],
  input  logic [DWIDTH-1:0]          ent_data [DEPTH],
  input  logic [DEPTH-1:0]           ent_vld,
  input  logic [$clog2(DEPTH)-1:0]   wr_idx,
  output logic                       hit_c,
  output logic [DWIDTH-1:0]          fwd_c
);

  localparam int unsigned PW = $clog2(DEPTH);

  // Walk from the oldest slot (wr_idx) towards the youngest; the last match wins.
  always_comb begin
    hit_c = 1'b0;
    fwd_c = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (ent_vld[wr_idx + PW'(k)] && (ent_addr[wr_idx + PW'(k)] == q_addr)) begin
        hit_c = 1'b1;
        fwd_c = ent_data[wr_idx + PW'(k)];
      end
    end
  end

endmodule

// File: rtl/reg_write_queue.sv
// In-order register write buffer draining one entry per cycle onto the bank
// write port, with two associative lookup ports for read forwarding.
module reg_write_queue
  import reg_write_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = RWQ_DEPTH,
  parameter int unsigned AWIDTH = REG_AW,
  parameter int unsigned DWIDTH = REG_DW
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [AWIDTH-1:0]          IN_ADDR,
  input  logic [DWIDTH-1:0]          IN_DATA,
  input  logic                       DRAIN_EN,
  output logic [AWIDTH-1:0]          AW,
  output logic [DWIDTH-1:0]          DIN,
  output logic                       REG_WRITE,
  input  logic [AWIDTH-1:0]          Q_AR1,
  input  logic [AWIDTH-1:0]          Q_AR2,
  output logic                       HIT1,
  output logic                       HIT2,
  output logic [DWIDTH-1:0]          FWD1,
  output logic [DWIDTH-1:0]          FWD2,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       EMPTY,
  output logic                       FULL
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW:0]        wr_ptr_q, wr_ptr_d;
  logic [PW:0]        rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [AWIDTH-1:0]  addr_q [DEPTH];
  logic [AWIDTH-1:0]  addr_d [DEPTH];
  logic [DWIDTH-1:0]  data_q [DEPTH];
  logic [DWIDTH-1:0]  data_d [DEPTH];

  logic [PW-1:0]      wr_idx, rd_idx;
  logic               empty_c, full_c, push_c, pop_c;

  assign wr_idx = wr_ptr_q[PW-1:0];
  assign rd_idx = rd_ptr_q[PW-1:0];

  // Extra pointer MSB separates full from empty when the indices coincide.
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_idx == rd_idx);
  assign push_c  = IN_VALID && !full_c;
  assign pop_c   = !empty_c && DRAIN_EN;

  assign IN_READY  = !full_c;
  assign EMPTY     = empty_c;
  assign FULL      = full_c;
  assign COUNT     = CW'(wr_ptr_q - rd_ptr_q);
  assign REG_WRITE = pop_c;
  assign AW        = empty_c ? '0 : addr_q[rd_idx];
  assign DIN       = empty_c ? '0 : data_q[rd_idx];

  // Next-state: push writes the tail slot, pop retires the head slot.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (push_c) begin
      addr_d[wr_idx] = IN_ADDR;
      data_d[wr_idx] = IN_DATA;
      vld_d[wr_idx]  = 1'b1;
      wr_ptr_d       = wr_ptr_q + CW'(1);
    end
    if (pop_c) begin
      vld_d[rd_idx] = 1'b0;
      rd_ptr_d      = rd_ptr_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
    end
  end

  // Payload storage needs no reset; every read is qualified by a valid bit or EMPTY.
  always_ff @(posedge CLK) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  rwq_match #(.DEPTH(DEPTH), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_match1 (
    .q_addr   (Q_AR1),
    .ent_addr (addr_q),
    .ent_data (data_q),
    .ent_vld  (vld_q),
    .wr_idx   (wr_idx),
    .hit_c    (HIT1),
    .fwd_c    (FWD1)
  );

  rwq_match #(.DEPTH(DEPTH), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_match2 (
    .q_addr   (Q_AR2),
    .ent_addr (addr_q),
    .ent_data (data_q),
    .ent_vld  (vld_q),
    .wr_idx   (wr_idx),
    .hit_c    (HIT2),
    .fwd_c    (FWD2)
  );

endmodule
